led_target_gen: RTL

- Stimulus side of the reflex game: drives the 16 target LEDs that the player must answer with the switches.
- Sits upstream of the match checker and score logic; consumes the player's `sw` and the game timer's expiry.
- Produces hit/miss events and a round count.
- An LFSR picks a new one-hot target each round. A round ends on a held match (hit) or a per-round timeout (miss).

---
 rtl/reflex_pkg.sv | 22 ++
 rtl/lfsr16.sv | 31 +++
 rtl/led_target_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex-game blocks: FSM states, LED width default,
// LFSR polynomial and the round counter width.
package reflex_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHOW,
        RESULT,
        DONE
    } state_e;

    localparam int          LED_W_DEF   = 16;
    localparam int          ROUND_CNT_W = 6;
    // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with a parameterised reset seed; steps every clock.
module lfsr16
    import reflex_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value_o
);

    generate
        if (SEED == 16'h0000) begin : g_bad_seed
            $error("lfsr16: SEED must be nonzero or the LFSR locks up");
        end
    endgenerate

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        // NOTE: registers take <= so every flop samples pre-edge values, independent of block order.
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/led_target_gen.sv
// Reflex-game stimulus: shows a random one-hot target, scores a held match as hit or a timeout as miss.
// Optional: define LED_TARGET_RANDOM_GAP_EN to insert a random 1..8 tick pause before each target.
module led_target_gen
    import reflex_pkg::*;
#(
    parameter int          LED_W         = LED_W_DEF,
    parameter int          ROUND_MAX     = 32,
    parameter int          HOLD_TICKS    = 2,
    parameter int          TIMEOUT_TICKS = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   time_up,
    input  logic [LED_W-1:0]       sw,
    output logic [LED_W-1:0]       led,
    output logic                   hit,
    output logic                   miss,
    output logic [ROUND_CNT_W-1:0] round_cnt,
    output logic                   busy,
    output logic                   done
);

    localparam int SEL_W  = $clog2(LED_W);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

    generate
        if (ROUND_MAX < 1 || ROUND_MAX > 63) begin : g_bad_round_max
            $error("led_target_gen: ROUND_MAX must be within 1..63");
        end
        if (LED_W < 2 || LED_W > 16 || (LED_W & (LED_W - 1)) != 0) begin : g_bad_led_w
            $error("led_target_gen: LED_W must be a power of two within 2..16");
        end
        if (HOLD_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_bad_ticks
            $error("led_target_gen: HOLD_TICKS and TIMEOUT_TICKS must be at least 1");
        end
    endgenerate

    logic [15:0] lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .value_o (lfsr)
    );

    state_e                 state_q, state_d;
    logic [LED_W-1:0]       target_q, target_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic [ROUND_CNT_W-1:0] rnd_q, rnd_d;
    logic                   scored_q, scored_d;

    logic [LED_W-1:0]       pick_raw, pick;
    logic [ROUND_CNT_W-1:0] rnd_inc;
    logic                   sw_zero, match, show_now;
    logic                   unused_lfsr_bits;

    // A repeat of the previous target is nudged one position left so the player always sees a change.
    assign pick_raw = LED_W'(1) << lfsr[SEL_W-1:0];
    assign pick     = (pick_raw == target_q) ? {pick_raw[LED_W-2:0], pick_raw[LED_W-1]} : pick_raw;

    assign sw_zero  = (sw == '0);
    assign match    = (sw == target_q);
    assign rnd_inc  = (rnd_q == '1) ? rnd_q : rnd_q + ROUND_CNT_W'(1);
    assign unused_lfsr_bits = ^lfsr[15:SEL_W];

`ifdef LED_TARGET_RANDOM_GAP_EN
    logic       armed_q, armed_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] gap_len_q, gap_len_d;

    // Pause length tracks the LFSR until the cycle ARM is entered, which latches it for the round.
    always_comb begin
        armed_d   = armed_q;
        gap_d     = gap_q;
        gap_len_d = gap_len_q;
        if (state_q != ARM) begin
            armed_d   = 1'b0;
            gap_len_d = {1'b0, lfsr[2:0]} + 4'd1;
        end else if (armed_q && !sw_zero) begin
            armed_d = 1'b0;
        end else if (tick && sw_zero) begin
            if (!armed_q) begin
                armed_d = 1'b1;
                gap_d   = gap_len_q;
            end else begin
                gap_d = gap_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed_q   <= 1'b0;
            gap_q     <= 4'd0;
            gap_len_q <= 4'd1;
        end else begin
            armed_q   <= armed_d;
            gap_q     <= gap_d;
            gap_len_q <= gap_len_d;
        end
    end

    assign show_now = armed_q && tick && sw_zero && (gap_q == 4'd1);
`else
    assign show_now = tick && sw_zero;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        target_d = target_q;
        hold_d   = hold_q;
        to_d     = to_q;
        rnd_d    = rnd_q;
        scored_d = scored_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    rnd_d   = '0;
                end
            end
            ARM: begin
                if (time_up) begin
                    state_d = DONE;
                end else if (show_now) begin
                    target_d = pick;
                    hold_d   = '0;
                    to_d     = '0;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (time_up) begin
                    state_d = DONE;
                end else if (tick) begin
                    hold_d = match ? hold_q + HOLD_W'(1) : '0;
                    to_d   = to_q + TO_W'(1);
                    // Hit is tested first so a match completing on the timeout tick still scores.
                    if (hold_d == HOLD_W'(HOLD_TICKS)) begin
                        scored_d = 1'b1;
                        state_d  = RESULT;
                    end else if (to_d == TO_W'(TIMEOUT_TICKS)) begin
                        scored_d = 1'b0;
                        state_d  = RESULT;
                    end
                end
            end
            RESULT: begin
                rnd_d   = rnd_inc;
                state_d = (time_up || rnd_inc == ROUND_CNT_W'(ROUND_MAX)) ? DONE : ARM;
            end
            DONE: begin
                if (start) begin
                    state_d = ARM;
                    rnd_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            hold_q   <= '0;
            to_q     <= '0;
            rnd_q    <= '0;
            scored_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
            rnd_q    <= rnd_d;
            scored_q <= scored_d;
        end
    end

    assign led       = (state_q == SHOW) ? target_q : '0;
    assign hit       = (state_q == RESULT) && scored_q;
    assign miss      = (state_q == RESULT) && !scored_q;
    assign round_cnt = rnd_q;
    assign busy      = state_q inside {ARM, SHOW, RESULT};
    assign done      = (state_q == DONE);

endmodule
